sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Writer-side counterpart to the sprite/background palette ROMs. Accepts a draw command, reads a W x H sprite frame from a 1-cycle-latency palette ROM, and writes its non-transparent palette indices into a 320x240 frame-buffer RAM.
- Sits between the game-logic command source (NIOS/PIO or the sprite scheduler) and the frame-buffer write port. The VGA side reads that frame buffer.
- One pixel per clock; clips against screen edges.

Parameters:
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- TRANSPARENT, 5'd0, palette index that is never written

Ports:
- Clk  in  1  system clock. Single clock domain.
- Reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_x  in  11  signed dest X of sprite top-left; may be negative or off-screen
- cmd_y  in  11  signed dest Y of sprite top-left
- cmd_w  in  7  sprite width, 0..64
- cmd_h  in  7  sprite height, 0..64
- cmd_base  in  17  ROM address of sprite frame pixel (0,0); frames are row-major
- rom_addr  out  17  palette ROM read address
- rom_data  in  5  palette index, valid the cycle after rom_addr
- fb_addr  out  17  frame-buffer write address, y*FB_W+x
- fb_data  out  5  palette index to write
- fb_we  out  1  frame-buffer write enable
- done  out  1  one-cycle pulse when a command finishes

Behaviour:
- Reset values: cmd_ready=1, rom_addr=0, fb_addr=0, fb_data=0, fb_we=0, done=0. State is IDLE.
- Handshake: a command is accepted on the edge where cmd_valid && cmd_ready. All cmd_* fields are latched on that edge. cmd_ready drops on the next cycle.
- States:
  - IDLE: accept a command. If w==0 or h==0, go to FIN. Otherwise go to RUN with row=0, col=0, rom_addr=cmd_base.
  - RUN: issue one rom_addr per cycle in raster order (col fastest), W*H cycles total. rom_addr increments by 1 per pixel and wraps mod 2^17. After issuing col=W-1, row=H-1, go to DRAIN.
  - DRAIN: one cycle, lets the last ROM read return. Then go to FIN.
  - FIN: one cycle. Return to IDLE.
- Pipeline, stage 0 (cycle n): present rom_addr. Compute dx=x+col and dy=y+row in 12-bit signed. Set inb = 0<=dx<FB_W && 0<=dy<FB_H. Register inb and the fb address (dy*FB_W+dx, computed as (dy<<8)+(dy<<6)+dx) alongside the pixel-valid tag.
- Pipeline, stage 1 (cycle n+1): rom_data arrives. At the n+2 edge, register fb_we = tag && inb && rom_data!=TRANSPARENT, plus fb_addr and fb_data=rom_data. A write is therefore visible 2 cycles after its rom_addr.
- fb_addr/fb_data hold their last values when fb_we=0. fb_we is never asserted for off-screen or transparent pixels.
- done pulses for exactly one cycle, in the cycle the last pixel's write slot is presented (FIN). cmd_ready returns high the following cycle.
- Total latency from accept to done:
  - W*H+2 cycles (RUN + DRAIN + FIN).
  - 1 cycle for zero-size commands: done pulses the cycle after accept, with no writes.
- cmd_valid while busy is ignored, with no queuing. The source holds the command until cmd_ready is high.
- Reset mid-command: next cycle IDLE, fb_we=0, no done pulse. The in-flight pipeline tag is cleared.
- Fully off-screen sprite: still takes W*H+2 cycles and produces zero writes.

Decomposition:
- Shared package blit_pkg holds:
  - FB_W and FB_H constants
  - PIX_W=5 (palette index width)
  - FB_AW=17 (frame-buffer address width)
  - TRANSPARENT
  - blit_state_t enum {IDLE, RUN, DRAIN, FIN}
  - blit_cmd_t packed struct {x, y, w, h, base}
- One natural sub-module: blit_addr_gen, holding the row/col counters, signed clip compare and y*320+x address. The FSM plus the write-stage register stay in sprite_blitter.

Test Plan:
1. Reset, then cmd x=10, y=5, w=4, h=2, base=100. ROM holds non-zero data at 100..107. Expect:
   - rom_addr 100..107 on consecutive cycles
   - 8 writes at fb_addr 1610..1613 and 1930..1933 with matching data
   - done exactly 10 cycles after accept
2. Same command with ROM[102]=0 and ROM[105]=0. Expect 6 writes; addresses 1612 and 1931 are never written.
3. Clipping, cmd x=-2, y=238, w=4, h=4. Expect only these writes: fb_addr 76160, 76161, 76480, 76481 (dx 0..1, dy 238..239). done after 18 cycles.
4. Zero size, w=0, h=3. Expect done the cycle after accept, no fb_we, cmd_ready high on the next cycle.
5. Back-to-back commands, with cmd_valid held high and two commands queued by the bench. Expect:
   - the second command accepted only in the cycle after the first done
   - no overlapping writes
   - cmd_ready low throughout RUN/DRAIN/FIN
6. Reset asserted 3 cycles into a w=8, h=8 command. Expect:
   - fb_we=0 from the next cycle
   - no done pulse
   - cmd_ready=1
   - a fresh command afterwards completes normally

Source files
------------

// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared constants and types for the sprite blitter
package blit_pkg;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int PIX_W = 5;
  localparam int FB_AW = 17;
  localparam logic [PIX_W-1:0] TRANSPARENT = 5'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} blit_state_t;

  typedef struct packed {
    logic [10:0]      x;
    logic [10:0]      y;
    logic [6:0]       w;
    logic [6:0]       h;
    logic [FB_AW-1:0] base;
  } blit_cmd_t;
endpackage

// File: rtl/blit_addr_gen.sv
// rtl/blit_addr_gen.sv - raster row/col walker with screen clip and fb address
module blit_addr_gen
  import blit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             step,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic [6:0]       w,
  input  logic [6:0]       h,
  output logic             last,
  output logic             inb,
  output logic [FB_AW-1:0] addr
);
  logic [10:0]        x_q, y_q;
  logic [6:0]         w_q, h_q, row, col;
  logic signed [11:0] dx, dy;

  // Latch sprite geometry on start, then walk pixels col-fastest one per step
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      row <= '0;
      col <= '0;
    end else if (start) begin
      x_q <= x;
      y_q <= y;
      w_q <= w;
      h_q <= h;
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == w_q - 7'd1) begin
        col <= '0;
        row <= row + 7'd1;
      end else begin
        col <= col + 7'd1;
      end
    end
  end

  assign last = (col == w_q - 7'd1) && (row == h_q - 7'd1);

  // Destination pixel in 12-bit signed so negative origins clip cleanly
  assign dx = $signed({x_q[10], x_q}) + $signed({5'b0, col});
  assign dy = $signed({y_q[10], y_q}) + $signed({5'b0, row});

  assign inb = !dx[11] && (dx < 12'(FB_W)) && !dy[11] && (dy < 12'(FB_H));

  // y*320 + x as two shifts and adds; only meaningful when inb is set
  assign addr = {1'b0, dy[7:0], 8'b0} + {3'b0, dy[7:0], 6'b0} + {8'b0, dx[8:0]};
endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - draws a clipped, transparency-keyed sprite into the frame buffer
module sprite_blitter
  import blit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [10:0]      cmd_x,
  input  logic [10:0]      cmd_y,
  input  logic [6:0]       cmd_w,
  input  logic [6:0]       cmd_h,
  input  logic [FB_AW-1:0] cmd_base,
  output logic [FB_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic [FB_AW-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             fb_we,
  output logic             done
);
  blit_state_t      state;
  blit_cmd_t        cmd;
  logic             accept, zero_size, step, last, inb, wr;
  logic             tag_q, inb_q;
  logic [FB_AW-1:0] pix_addr, addr_q;

  assign cmd       = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, base: cmd_base};
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign zero_size = (cmd.w == 7'd0) || (cmd.h == 7'd0);
  assign step      = (state == RUN);
  assign done      = (state == FIN);

  blit_addr_gen u_addr_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .start (accept && !zero_size),
    .step  (step),
    .x     (cmd.x),
    .y     (cmd.y),
    .w     (cmd.w),
    .h     (cmd.h),
    .last  (last),
    .inb   (inb),
    .addr  (pix_addr)
  );

  // Command sequencing: IDLE -> RUN (W*H cycles) -> DRAIN -> FIN, zero-size skips to FIN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= zero_size ? FIN : RUN;
        RUN:     if (last) state <= DRAIN;
        DRAIN:   state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ROM read address: load sprite base on accept, advance one pixel per RUN cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
    end else if (accept) begin
      rom_addr <= cmd.base;
    end else if (step) begin
      rom_addr <= rom_addr + 17'd1;
    end
  end

  // Stage 0: carry clip result and fb address alongside the ROM read in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_q  <= 1'b0;
      inb_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      tag_q  <= step;
      inb_q  <= inb;
      addr_q <= pix_addr;
    end
  end

  assign wr = tag_q && inb_q && (rom_data != TRANSPARENT);

  // Stage 1: issue the write; address/data hold when nothing is written
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= wr;
      if (wr) begin
        fb_addr <= addr_q;
        fb_data <= rom_data;
      end
    end
  end
endmodule
